// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing-check blocks: measurement FSM
// encoding and the default counter width.
package vga_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_t;

endpackage

// File: rtl/clk_period_meter_if.sv
// Result bus of the period meter: registered period/high counts with a
// one-cycle update strobe plus lock and timeout status.
interface clk_period_meter_if #(
    parameter int CNT_W = vga_pkg::CNT_W_DEF
);
    logic [CNT_W-1:0] O_PERIOD;
    logic [CNT_W-1:0] O_HIGH;
    logic             O_VALID;
    logic             O_LOCKED;
    logic             O_TIMEOUT;

    modport master (
        output O_PERIOD, O_HIGH, O_VALID, O_LOCKED, O_TIMEOUT
    );

    modport slave (
        input  O_PERIOD, O_HIGH, O_VALID, O_LOCKED, O_TIMEOUT
    );
endinterface

// File: rtl/sig_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus rising-edge
// detection on the synchronized copy.
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic I_CLK,
    input  logic rst_n,
    input  logic clr,
    input  logic I_SIG,
    output logic O_LVL,
    output logic O_RISE
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl_d;

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_lvl_d <= 1'b0;
        end else if (clr) begin
            r_sync  <= '0;
            r_lvl_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], I_SIG};
            r_lvl_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign O_LVL  = r_sync[SYNC_STAGES-1];
    assign O_RISE = r_sync[SYNC_STAGES-1] & ~r_lvl_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in I_CLK
// cycles, with a valid strobe per period and a sticky no-edge timeout.
module clk_period_meter
    import vga_pkg::*;
#(
    parameter int     CNT_W       = CNT_W_DEF,
    parameter int     SYNC_STAGES = 2,
    parameter longint TIMEOUT     = 1000000
) (
    input  logic                I_CLK,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                I_SIG,
    clk_period_meter_if.master  o_meas
);
    localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT);

    meas_state_t      r_state;
    meas_state_t      w_state_nxt;
    logic             w_lvl;
    logic             w_rise;
    logic             w_arm;
    logic             w_take;
    logic             w_expire;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_locked;
    logic             r_timeout;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .I_CLK  (I_CLK),
        .rst_n  (rst_n),
        .clr    (clr),
        .I_SIG  (I_SIG),
        .O_LVL  (w_lvl),
        .O_RISE (w_rise)
    );

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A rise coinciding with pcnt == TIMEOUT is a valid measurement, not a timeout.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:    if (w_rise) w_state_nxt = ST_MEASURE;
                ST_MEASURE: if (!w_rise && (r_pcnt == LP_TMO)) w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_arm    = (r_state == ST_IDLE) && w_rise;
        w_take   = (r_state == ST_MEASURE) && w_rise;
        w_expire = (r_state == ST_MEASURE) && !w_rise && (r_pcnt == LP_TMO);
    end

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (clr || w_expire) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (w_arm || w_take) begin
            r_pcnt <= CNT_W'(1);
            r_hcnt <= CNT_W'(1);
        end else if (r_state == ST_MEASURE) begin
            r_pcnt <= r_pcnt + CNT_W'(1);
            r_hcnt <= r_hcnt + CNT_W'(w_lvl);
        end
    end

    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else if (clr) begin
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= w_take;
            if (w_take) begin
                r_period <= r_pcnt;
                r_high   <= r_hcnt;
                r_locked <= 1'b1;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
                r_locked  <= 1'b0;
            end
            if (w_arm) r_timeout <= 1'b0;
        end
    end

    assign o_meas.O_PERIOD  = r_period;
    assign o_meas.O_HIGH    = r_high;
    assign o_meas.O_VALID   = r_valid;
    assign o_meas.O_LOCKED  = r_locked;
    assign o_meas.O_TIMEOUT = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter (TIMEOUT=50): table of square waves
// plus hand-written timeout, async-reset and clear-on-rise sequences.
module tb_clk_period_meter;
    import vga_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic sig   = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          v_cyc[$];
    logic [31:0] v_per[$];
    logic [31:0] v_hi[$];

    typedef struct {
        int          hi;
        int          lo;
        int          nper;
        logic [31:0] exp_period;
        logic [31:0] exp_high;
    } vec_t;

    vec_t vecs[5];

    clk_period_meter_if #(.CNT_W(32)) u_if ();

    clk_period_meter #(
        .CNT_W       (32),
        .SYNC_STAGES (2),
        .TIMEOUT     (50)
    ) dut (
        .I_CLK  (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .I_SIG  (sig),
        .o_meas (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.O_VALID) begin
            v_cyc.push_back(cyc);
            v_per.push_back(u_if.O_PERIOD);
            v_hi.push_back(u_if.O_HIGH);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_clr();
        sig = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // nper full periods followed by one closing rise held long enough to be measured.
    task automatic run_wave(input int hi, input int lo, input int nper);
        for (int p = 0; p < nper; p++) begin
            sig = 1'b1;
            repeat (hi) @(negedge clk);
            sig = 1'b0;
            repeat (lo) @(negedge clk);
        end
        sig = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [66:0] outs();
        return {u_if.O_PERIOD, u_if.O_HIGH, u_if.O_VALID, u_if.O_LOCKED, u_if.O_TIMEOUT};
    endfunction

    initial begin
        int base;
        int t_to;
        int nv;
        bit seen;

        vecs[0] = '{hi: 10, lo: 10, nper: 4, exp_period: 32'd20, exp_high: 32'd10};
        vecs[1] = '{hi: 3,  lo: 7,  nper: 5, exp_period: 32'd10, exp_high: 32'd3};
        vecs[2] = '{hi: 1,  lo: 1,  nper: 5, exp_period: 32'd2,  exp_high: 32'd1};
        vecs[3] = '{hi: 25, lo: 24, nper: 3, exp_period: 32'd49, exp_high: 32'd25};
        vecs[4] = '{hi: 40, lo: 10, nper: 3, exp_period: 32'd50, exp_high: 32'd40};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(outs()), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_clr();
            base = v_per.size();
            run_wave(vecs[i].hi, vecs[i].lo, vecs[i].nper);
            chk($sformatf("v%0d_pulses", i), 64'(v_per.size() - base), 64'(vecs[i].nper));
            for (int k = base; k < v_per.size(); k++) begin
                chk($sformatf("v%0d_period%0d", i, k - base), 64'(v_per[k]), 64'(vecs[i].exp_period));
                chk($sformatf("v%0d_high%0d", i, k - base), 64'(v_hi[k]), 64'(vecs[i].exp_high));
                if (k > base)
                    chk($sformatf("v%0d_spacing%0d", i, k - base), 64'(v_cyc[k] - v_cyc[k-1]),
                        64'(vecs[i].exp_period));
            end
            chk($sformatf("v%0d_locked", i), 64'(u_if.O_LOCKED), 64'd1);
            chk($sformatf("v%0d_timeout", i), 64'(u_if.O_TIMEOUT), 64'd0);
        end

        // Timeout after locking on a 20-cycle wave.
        do_clr();
        run_wave(10, 10, 2);
        sig = 1'b0;
        seen = 1'b0;
        t_to = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (u_if.O_TIMEOUT) begin
                seen = 1'b1;
                t_to = cyc;
            end
        end
        chk("tmo_seen", 64'(seen), 64'd1);
        chk("tmo_delay", 64'(t_to - v_cyc[v_cyc.size()-1]), 64'd50);
        chk("tmo_locked", 64'(u_if.O_LOCKED), 64'd0);
        chk("tmo_period_kept", 64'(u_if.O_PERIOD), 64'd20);
        base = v_per.size();
        sig = 1'b1;
        repeat (5) @(negedge clk);
        chk("tmo_cleared_on_arm", 64'(u_if.O_TIMEOUT), 64'd0);
        chk("tmo_no_valid_on_arm", 64'(v_per.size() - base), 64'd0);
        repeat (10) @(negedge clk);
        sig = 1'b0;
        repeat (15) @(negedge clk);
        sig = 1'b1;
        repeat (4) @(negedge clk);
        nv = v_per.size() - base;
        chk("tmo_relock_pulses", 64'(nv), 64'd1);
        if (nv > 0) chk("tmo_relock_period", 64'(v_per[base]), 64'd30);
        chk("tmo_relock_timeout", 64'(u_if.O_TIMEOUT), 64'd0);
        sig = 1'b0;

        // Asynchronous reset in the middle of a high phase.
        do_clr();
        run_wave(10, 10, 1);
        sig = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_locked_before", 64'(u_if.O_LOCKED), 64'd1);
        rst_n = 1'b0;
        sig   = 1'b0;
        #1;
        chk("arst_outputs_now", 64'(outs()), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        base = v_per.size();
        sig = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_first_rise_arms", 64'(v_per.size() - base), 64'd0);
        sig = 1'b0;
        repeat (10) @(negedge clk);
        sig = 1'b1;
        repeat (4) @(negedge clk);
        nv = v_per.size() - base;
        chk("arst_second_rise", 64'(nv), 64'd1);
        if (nv > 0) begin
            chk("arst_period", 64'(v_per[base]), 64'd20);
            chk("arst_high", 64'(v_hi[base]), 64'd10);
        end
        sig = 1'b0;

        // Synchronous clear landing on the rise-detection cycle.
        do_clr();
        run_wave(10, 10, 2);
        sig = 1'b0;
        repeat (10) @(negedge clk);
        chk("clr_locked_before", 64'(u_if.O_LOCKED), 64'd1);
        base = v_per.size();
        sig = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_outputs", 64'(outs()), 64'd0);
        chk("clr_state_idle", 64'(dut.r_state), 64'(ST_IDLE));
        repeat (8) @(negedge clk);
        chk("clr_no_valid", 64'(v_per.size() - base), 64'd0);
        sig = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, asynchronous square wave (typically a divided clock produced elsewhere in the VGA design) in `I_CLK` cycles. It synchronizes the input, detects rising edges, and publishes period and high-time counts with a one-cycle valid strobe. It flags a timeout when the input stops toggling. It is the consumer/checker counterpart to the clock dividers: it lets the design and the benches confirm divider ratios and duty cycles at run time.

## Interface
- `CNT_W`, 32: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchronizer; must be ≥ 2.
- `TIMEOUT`, 1000000: cycles without a rising edge before timeout; 2 ≤ `TIMEOUT` ≤ 2^`CNT_W`−1.
- `I_CLK` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset. Release is synchronous to `I_CLK` upstream.
- `clr` in 1: synchronous clear. Same effect as reset, but not asynchronous.
- `I_SIG` in 1: asynchronous square wave under measurement.
- `O_PERIOD` out `CNT_W`: last measured period, in `I_CLK` cycles.
- `O_HIGH` out `CNT_W`: high time of the last measured period, in `I_CLK` cycles.
- `O_VALID` out 1: one-cycle pulse when `O_PERIOD`/`O_HIGH` update.
- `O_LOCKED` out 1: at least one valid measurement since the last reset, clear or timeout.
- `O_TIMEOUT` out 1: sticky; no edge seen within `TIMEOUT` cycles.

## Operation
- **Synchronizer.** `I_SIG` passes through `SYNC_STAGES` flops to give `s`. One more flop gives `s_d`. A rise is detected when `s & ~s_d`.
- **States.** Two states: `IDLE` (waiting for the first edge) and `MEASURE`.
- **Reset/clear values.** State `IDLE`. Counters `pcnt` and `hcnt` = 0. Synchronizer flops = 0. All outputs = 0.
- **IDLE:**
  - Counters hold at 0.
  - On a rise: `pcnt`←1, `hcnt`←1, go to `MEASURE`, clear `O_TIMEOUT`.
  - No `O_VALID` from this first edge.
- **MEASURE, cycle without a rise:**
  - `pcnt`←`pcnt`+1.
  - `hcnt`←`hcnt`+1 if `s`=1, otherwise `hcnt` holds.
- **MEASURE, cycle with a rise:**
  - `O_PERIOD`←`pcnt`, `O_HIGH`←`hcnt`.
  - `O_VALID`←1 for one cycle, `O_LOCKED`←1.
  - `pcnt`←1, `hcnt`←1.
- **Period definition.** The period equals the number of `I_CLK` cycles between two consecutive rise detections. For an input 10 cycles high and 10 low: `O_PERIOD`=20, `O_HIGH`=10.
- **Timeout:**
  - Triggers in `MEASURE` when `pcnt`==`TIMEOUT` and there is no rise that cycle.
  - Effects: `O_TIMEOUT`←1, `O_LOCKED`←0, counters←0, state←`IDLE`.
  - `O_PERIOD`/`O_HIGH` keep their last values.
- **Arithmetic.** Unsigned. `pcnt` never exceeds `TIMEOUT`, so no wrap and no saturation logic is needed. `hcnt` ≤ `pcnt` always holds.
- **Simultaneous events:**
  - `clr` beats everything.
  - A rise on the same cycle as `pcnt`==`TIMEOUT` is a valid measurement with period `TIMEOUT`, not a timeout.
- **Reset mid-period.** The partial measurement is discarded. The first edge after release only arms the meter.
- **Constant input.** `I_SIG` held high or low never produces a valid measurement. It times out `TIMEOUT` cycles after the last rise.

## Timing
- Edge on `I_SIG` to rise detection: `SYNC_STAGES`+1 `I_CLK` edges (±1 cycle of synchronizer uncertainty).
- Rise detection to outputs: `O_PERIOD`, `O_HIGH`, `O_VALID` and `O_LOCKED` are registered and update on the clock edge that ends the detection cycle.
- `O_VALID` is never high on two consecutive cycles. Minimum measurable period is 2 cycles.
- Input high or low phases shorter than one `I_CLK` period may be missed. That is a documented limitation, not an error.
- `O_TIMEOUT` rises on the edge ending the cycle with `pcnt`==`TIMEOUT`.

## Structure
- **Shared package** (`vga_pkg`): state encoding constants `ST_IDLE` and `ST_MEASURE`, and the default `CNT_W`.
- **Sub-module `sig_sync_edge`** (parameter `SYNC_STAGES`):
  - Ports: `I_CLK`, `rst_n`, `clr`, `I_SIG`, `O_LVL` (= `s`), `O_RISE`.
  - Reused elsewhere for button and VSYNC edge detection.
- **Top:** state register, counters and output registers.

## Test plan
- **Divider-ratio check.** Drive `I_SIG` 10 high / 10 low for 5 periods. Required:
  - No `O_VALID` on the first rise.
  - Then 4 pulses, each with `O_PERIOD`=20 and `O_HIGH`=10.
  - `O_LOCKED`=1 after the first pulse.
- **Asymmetric duty.** Drive 3 high / 7 low. Required: `O_PERIOD`=10, `O_HIGH`=3. Consecutive `O_VALID` pulses are exactly 10 cycles apart.
- **Timeout.** Set `TIMEOUT`=50, lock on a 20-cycle wave, then hold `I_SIG`=0. Required:
  - `O_TIMEOUT`=1 and `O_LOCKED`=0 at 50 cycles after the last detection.
  - `O_PERIOD` stays 20.
  - The next two rises (30 cycles apart) give a single `O_VALID` with `O_PERIOD`=30, and clear `O_TIMEOUT`.
- **Timeout boundary.** With `TIMEOUT`=50, place rises exactly 50 cycles apart. Required: `O_VALID` with `O_PERIOD`=50 and `O_TIMEOUT` stays 0.
- **Asynchronous reset mid-period.** Assert `rst_n`=0 between edges. Required:
  - All outputs go to 0 immediately, without a clock.
  - After release, the first rise yields no `O_VALID`.
  - The second rise yields the correct period.
- **Clear on a rise cycle.** Assert `clr` on the same cycle as a rise detection. Required: no `O_VALID`, outputs 0, state `IDLE`.
